// File: rtl/mul_seq_ctrl_if.sv
// Operand/product handshake bundle for the sequential multiplier.
// The master drives operands and takes the product; the slave is the multiply unit.
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product_lo;
    logic [WIDTH-1:0] product_hi;
    logic             busy;

    modport master (
        output in_valid, a, b, abort, out_ready,
        input  in_ready, out_valid, product_lo, product_hi, busy
    );

    modport slave (
        input  in_valid, a, b, abort, out_ready,
        output in_ready, out_valid, product_lo, product_hi, busy
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-and-add multiplier: consumes STEP multiplier bits per cycle and
// accumulates shifted partial products into a 2*WIDTH result.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | accumulating partial products, one STEP-bit digit per cycle
// DONE  | product held on the outputs until the consumer takes it
module mul_seq_ctrl #(
    parameter int WIDTH      = 32,
    parameter int STEP       = 1,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_seq_ctrl_if.slave    bus
);
    localparam int             STEPS = WIDTH / STEP;
    localparam int             CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0]  LAST  = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mplier_nxt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] addend;
    logic [CW-1:0]      cnt;
    logic               finish;

    // Partial product is formed at full 2*WIDTH so the shift never truncates.
    always_comb begin
        addend     = ({{(2*WIDTH-STEP){1'b0}}, mplier[STEP-1:0]} * {{WIDTH{1'b0}}, mcand})
                     << (int'(cnt) * STEP);
        acc_nxt    = acc + addend;
        mplier_nxt = mplier >> STEP;
        finish     = (cnt == LAST) || ((EARLY_EXIT != 0) && (mplier_nxt == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.product_lo <= '0;
            bus.product_hi <= '0;
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            cnt            <= '0;
        end else if (bus.abort && (state != IDLE)) begin
            // Result is dropped; product registers keep the previous value.
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand        <= bus.a;
                        mplier       <= bus.b;
                        acc          <= '0;
                        cnt          <= '0;
                        state        <= RUN;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + 1'b1;
                    if (finish) begin
                        state          <= DONE;
                        bus.out_valid  <= 1'b1;
                        bus.product_lo <= acc_nxt[WIDTH-1:0];
                        bus.product_hi <= acc_nxt[2*WIDTH-1:WIDTH];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: three instances cover STEP=1, STEP=4 and early exit.
module tb_mul_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl_if #(.WIDTH(32)) if0 ();
    mul_seq_ctrl_if #(.WIDTH(32)) if1 ();
    mul_seq_ctrl_if #(.WIDTH(32)) if2 ();

    mul_seq_ctrl #(.WIDTH(32), .STEP(1), .EARLY_EXIT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mul_seq_ctrl #(.WIDTH(32), .STEP(4), .EARLY_EXIT(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mul_seq_ctrl #(.WIDTH(32), .STEP(1), .EARLY_EXIT(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int u, input logic v, input logic [31:0] av, input logic [31:0] bv);
        case (u)
            0: begin if0.in_valid = v; if0.a = av; if0.b = bv; end
            1: begin if1.in_valid = v; if1.a = av; if1.b = bv; end
            default: begin if2.in_valid = v; if2.a = av; if2.b = bv; end
        endcase
    endtask

    function automatic logic ov(input int u);
        case (u)
            0: return if0.out_valid;
            1: return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic [63:0] prod(input int u);
        case (u)
            0: return {if0.product_hi, if0.product_lo};
            1: return {if1.product_hi, if1.product_lo};
            default: return {if2.product_hi, if2.product_lo};
        endcase
    endfunction

    // Called #1 after an accept edge; counts edges until out_valid is seen.
    task automatic wait_done(input int u, output int lat);
        lat = 0;
        while (!ov(u) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) chk("timeout", 64'(lat), 64'd0);
    endtask

    task automatic op(input int u, input logic [31:0] av, input logic [31:0] bv,
                      output int lat, output logic [63:0] p);
        set_in(u, 1'b1, av, bv);
        @(posedge clk); #1;
        set_in(u, 1'b0, '0, '0);
        wait_done(u, lat);
        p = prod(u);
    endtask

    int          lat;
    logic [63:0] p;
    logic        seen;
    logic [31:0] ra, rb;

    initial begin
        for (int u = 0; u < 3; u++) set_in(u, 1'b0, '0, '0);
        if0.abort = 0; if1.abort = 0; if2.abort = 0;
        if0.out_ready = 1; if1.out_ready = 1; if2.out_ready = 1;

        #2 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 64'(if0.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
        chk("rst_busy", 64'(if0.busy), 64'd0);
        chk("rst_product", prod(0), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        op(0, 32'd3, 32'd5, lat, p);
        chk("t1_latency", 64'(lat), 64'd32);
        chk("t1_product", p, 64'h0000_0000_0000_000F);
        @(posedge clk); #1;
        chk("t1_in_ready_back", 64'(if0.in_ready), 64'd1);
        chk("t1_out_valid_low", 64'(if0.out_valid), 64'd0);

        op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p);
        chk("t2_max_product", p, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;
        op(0, 32'h8000_0000, 32'd2, lat, p);
        chk("t2_carry_product", p, 64'h0000_0001_0000_0000);
        @(posedge clk); #1;

        // Backpressure: product held while a new operand is waiting.
        if0.out_ready = 0;
        op(0, 32'd10, 32'd20, lat, p);
        set_in(0, 1'b1, 32'd1, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3_hold_valid", 64'(if0.out_valid), 64'd1);
            chk("t3_hold_product", prod(0), 64'd200);
            chk("t3_hold_in_ready", 64'(if0.in_ready), 64'd0);
        end
        if0.out_ready = 1;
        @(posedge clk); #1;
        chk("t3_handshake_valid", 64'(if0.out_valid), 64'd0);
        chk("t3_handshake_in_ready", 64'(if0.in_ready), 64'd1);
        @(posedge clk); #1;
        set_in(0, 1'b0, '0, '0);
        chk("t3_next_busy", 64'(if0.busy), 64'd1);
        wait_done(0, lat);
        chk("t3_next_latency", 64'(lat), 64'd32);
        chk("t3_next_product", prod(0), 64'd1);
        @(posedge clk); #1;

        // Abort mid-RUN.
        set_in(0, 1'b1, 32'd100, 32'd100);
        @(posedge clk); #1;
        set_in(0, 1'b0, '0, '0);
        repeat (9) begin @(posedge clk); #1; end
        if0.abort = 1;
        @(posedge clk); #1;
        if0.abort = 0;
        chk("t4_abort_busy", 64'(if0.busy), 64'd0);
        chk("t4_abort_in_ready", 64'(if0.in_ready), 64'd1);
        chk("t4_abort_product_kept", prod(0), 64'd1);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (if0.out_valid) seen = 1; end
        chk("t4_no_out_valid", 64'(seen), 64'd0);
        op(0, 32'd7, 32'd6, lat, p);
        chk("t4_after_abort", p, 64'd42);
        @(posedge clk); #1;

        // Abort in IDLE is ignored and the same-cycle operand is accepted.
        if0.abort = 1;
        set_in(0, 1'b1, 32'd5, 32'd9);
        @(posedge clk); #1;
        if0.abort = 0;
        set_in(0, 1'b0, '0, '0);
        chk("t4_idle_abort_busy", 64'(if0.busy), 64'd1);
        wait_done(0, lat);
        chk("t4_idle_abort_product", prod(0), 64'd45);
        @(posedge clk); #1;

        // Abort beats out_ready in DONE.
        if0.out_ready = 0;
        op(0, 32'd11, 32'd13, lat, p);
        chk("t4_done_product", p, 64'd143);
        if0.abort = 1; if0.out_ready = 1;
        @(posedge clk); #1;
        if0.abort = 0;
        chk("t4_done_abort_valid", 64'(if0.out_valid), 64'd0);
        chk("t4_done_abort_in_ready", 64'(if0.in_ready), 64'd1);
        chk("t4_done_abort_product", prod(0), 64'd143);

        // Async reset mid-RUN.
        set_in(0, 1'b1, 32'd100, 32'd100);
        @(posedge clk); #1;
        set_in(0, 1'b0, '0, '0);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 64'(if0.busy), 64'd0);
        chk("t5_rst_in_ready", 64'(if0.in_ready), 64'd1);
        chk("t5_rst_out_valid", 64'(if0.out_valid), 64'd0);
        chk("t5_rst_product", prod(0), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        op(0, 32'd2, 32'd3, lat, p);
        chk("t5_latency", 64'(lat), 64'd32);
        chk("t5_product", p, 64'd6);
        @(posedge clk); #1;

        // STEP=4 and early exit.
        op(1, 32'h1234_5678, 32'h9ABC_DEF0, lat, p);
        chk("t6_step4_latency", 64'(lat), 64'd8);
        chk("t6_step4_product", p, 64'h0B00_EA4E_242D_2080);
        @(posedge clk); #1;
        op(1, 32'd9, 32'd1, lat, p);
        chk("t6_step4_b1_latency", 64'(lat), 64'd8);
        @(posedge clk); #1;
        op(2, 32'hDEAD_BEEF, 32'd1, lat, p);
        chk("t6_ee_b1_latency", 64'(lat), 64'd1);
        chk("t6_ee_b1_product", p, 64'h0000_0000_DEAD_BEEF);
        @(posedge clk); #1;
        op(2, 32'hDEAD_BEEF, 32'd0, lat, p);
        chk("t6_ee_b0_latency", 64'(lat), 64'd1);
        chk("t6_ee_b0_product", p, 64'd0);
        @(posedge clk); #1;
        op(2, 32'd5, 32'h0000_0100, lat, p);
        chk("t6_ee_msb8_latency", 64'(lat), 64'd9);
        chk("t6_ee_msb8_product", p, 64'h500);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom;
            op(i % 2, ra, rb, lat, p);
            chk("rand_latency", 64'(lat), (i % 2 == 0) ? 64'd32 : 64'd8);
            chk("rand_product", p, {32'd0, ra} * {32'd0, rb});
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
